arbitro_alu: RTL
================

// Module: arbitro_alu
// PURPOSE
//   Shares one combinational ALU (N-bit, 3-bit Sel: add/sub/mul/mod/shr/passB)
//   between two requesters over valid/ready. Round-robin grant, registered ALU
//   operands, registered result+flags, one tagged response channel.
//   Per-requester saturating completion counters. Sits between issue logic and the ALU.
// PARAMETERS
//   N   32  operand/result width (must match the ALU instance)
//   CW  16  width of per-requester completion counters
// PORTS
//   clk         in   1    clock, all state on rising edge
//   rst         in   1    synchronous reset, active-high
//   req0_valid  in   1    requester 0 has an operation
//   req0_ready  out  1    requester 0 accepted this cycle
//   req0_a      in   N    requester 0 operand A
//   req0_b      in   N    requester 0 operand B
//   req0_sel    in   3    requester 0 ALU Sel
//   req1_valid/req1_ready/req1_a/req1_b/req1_sel   same as req0, for requester 1
//   alu_a       out  N    to ALU A (registered)
//   alu_b       out  N    to ALU B (registered)
//   alu_sel     out  3    to ALU Sel (registered)
//   alu_c       in   N    ALU result C
//   alu_flags   in   4    ALU flags {neg,zero,ovf,carry}
//   rsp_valid   out  1    response available
//   rsp_ready   in   1    consumer takes response
//   rsp_c       out  N    captured result
//   rsp_flags   out  4    captured {neg,zero,ovf,carry}
//   rsp_id      out  1    requester that issued the op
//   cnt0        out  CW   responses delivered to requester 0 (saturating)
//   cnt1        out  CW   responses delivered to requester 1 (saturating)
// BEHAVIOUR
//   - FSM: IDLE -> EXEC -> RESP -> IDLE. One op in flight.
//   - Reset: state IDLE, last_grant=1; all outputs 0 (alu_*, rsp_*, cnt*, ready).
//   - IDLE grant: one valid -> that one; both valid -> !last_grant; none -> stay.
//     reqX_ready=1 only in IDLE for granted X (comb. on both valids).
//     Accept (valid&ready): latch a/b/sel into alu_*, id; last_grant<=X; -> EXEC.
//   - EXEC (1 cycle): alu_* stable; alu_c/alu_flags captured into rsp_c/rsp_flags
//     at cycle end; rsp_valid<=1; -> RESP.
//   - RESP: rsp_* held stable while rsp_valid&!rsp_ready (any length);
//     rsp_valid&rsp_ready -> rsp_valid<=0, cnt[rsp_id]+=1, -> IDLE.
//   - Latency: accept at edge T -> rsp_valid high from T+2. Max throughput 1 op
//     per 3 cycles (rsp_ready tied 1). No accept in EXEC/RESP.
//   - Sel passed unchanged (110/111 included); no decode, no flag masking;
//     ALU owns flag gating.
//   - alu_* keep last op after completion (no glitch to ALU), cleared only by rst.
//   - Counters saturate at 2^CW-1, no wrap.
//   - rst in any state: next cycle IDLE, in-flight op dropped, no response,
//     counters 0, last_grant=1.
//   - Requester dropping valid before ready: legal, nothing accepted.
// TESTING
//   1 rst 2 cycles -> every output 0; first tie after rst goes to req0.
//   2 req0 add: a=5,b=3,sel=000 accepted T -> rsp_valid T+2, c=8, flags=0000, id=0.
//   3 req1 sub: a=3,b=5,sel=001 -> c=0xFFFFFFFE, neg flag=1, id=1, cnt1=1.
//   4 both valid continuously, rsp_ready=1 -> ids 0,1,0,1, one accept per 3 cycles.
//   5 rsp_ready=0 for 5 cycles in RESP -> rsp_c/flags/id stable, both ready 0;
//     rsp_ready=1 -> accept of next op on following cycle.
//   6 rst during EXEC -> rsp_valid stays 0, cnt0/cnt1=0; CW=2, 5 responses
//     to req0 -> cnt0=3.

Source files
------------

// File: rtl/arbitro_alu.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Registers operands to the ALU, captures result+flags and returns them tagged with the issuer.
module arbitro_alu #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [N-1:0]  req0_a,
    input  logic [N-1:0]  req0_b,
    input  logic [2:0]    req0_sel,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [N-1:0]  req1_a,
    input  logic [N-1:0]  req1_b,
    input  logic [2:0]    req1_sel,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [2:0]    alu_sel,
    input  logic [N-1:0]  alu_c,
    input  logic [3:0]    alu_flags,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_c,
    output logic [3:0]    rsp_flags,
    output logic          rsp_id,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

    stateT          stateReg, stateNext;
    logic           lastGrantReg;
    logic           idReg;
    logic [N-1:0]   aluAReg, aluBReg;
    logic [2:0]     aluSelReg;
    logic           rspValidReg;
    logic [N-1:0]   rspCReg;
    logic [3:0]     rspFlagsReg;
    logic           grant;
    logic           ready0, ready1;
    logic           accept;
    logic           rspFire;
    logic [CW-1:0]  cntVec [2];

    always_comb begin
        stateNext = stateReg;
        grant     = 1'b0;
        ready0    = 1'b0;
        ready1    = 1'b0;
        rspFire   = 1'b0;
        // On a tie the requester that did not win last time goes first
        if (req0_valid && req1_valid) begin
            grant = ~lastGrantReg;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        case (stateReg)
            IDLE: begin
                if (!rst) begin
                    ready0 = req0_valid && !grant;
                    ready1 = req1_valid && grant;
                end
                if (ready0 || ready1) begin
                    stateNext = EXEC;
                end
            end
            EXEC: stateNext = RESP;
            RESP: begin
                if (rsp_ready) begin
                    rspFire   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign accept = ready0 || ready1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= IDLE;
            lastGrantReg <= 1'b1;
            idReg        <= 1'b0;
            aluAReg      <= '0;
            aluBReg      <= '0;
            aluSelReg    <= '0;
            rspValidReg  <= 1'b0;
            rspCReg      <= '0;
            rspFlagsReg  <= '0;
        end else begin
            stateReg <= stateNext;
            if (accept) begin
                aluAReg      <= grant ? req1_a   : req0_a;
                aluBReg      <= grant ? req1_b   : req0_b;
                aluSelReg    <= grant ? req1_sel : req0_sel;
                idReg        <= grant;
                lastGrantReg <= grant;
            end
            if (stateReg == EXEC) begin
                rspCReg     <= alu_c;
                rspFlagsReg <= alu_flags;
                rspValidReg <= 1'b1;
            end
            if (rspFire) begin
                rspValidReg <= 1'b0;
            end
        end
    end

    // Per-requester completion counters, saturating at all-ones
    for (genvar gi = 0; gi < 2; gi++) begin : genCnt
        logic [CW-1:0] cntReg;
        always_ff @(posedge clk) begin
            if (rst) begin
                cntReg <= '0;
            end else if (rspFire && (idReg == 1'(gi)) && (cntReg != '1)) begin
                cntReg <= cntReg + 1'b1;
            end
        end
        assign cntVec[gi] = cntReg;
    end

    assign req0_ready = ready0;
    assign req1_ready = ready1;
    assign alu_a      = aluAReg;
    assign alu_b      = aluBReg;
    assign alu_sel    = aluSelReg;
    assign rsp_valid  = rspValidReg;
    assign rsp_c      = rspCReg;
    assign rsp_flags  = rspFlagsReg;
    assign rsp_id     = idReg;
    assign cnt0       = cntVec[0];
    assign cnt1       = cntVec[1];

endmodule
